// File: rtl/joint_pwmdir_nch.sv
// Multi-channel PWM/DIR joint driver: shared period counter, signed duty latched only at period boundaries.
// Latency: a command seen on the last period cycle drives PWM from the next cycle; reversals add DEADTIME with PWM low.
// Backpressure: none; commands that change between boundaries are ignored.
module joint_pwmdir_nch #(
    parameter int CHANNELS   = 4,
    parameter int PWM_PERIOD = 1000,
    parameter int DEADTIME   = 50,
    parameter int CMD_WIDTH  = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [CHANNELS-1:0]           jointEnable,
    input  logic [CHANNELS*CMD_WIDTH-1:0] jointDutyCmd,
    output logic [CHANNELS*CMD_WIDTH-1:0] jointFeedback,
    output logic [CHANNELS-1:0]           DIR,
    output logic [CHANNELS-1:0]           PWM
);
    localparam int CNTW = $clog2(PWM_PERIOD);
    localparam int DW   = $clog2(PWM_PERIOD + 1);
    localparam int DTW  = (DEADTIME > 1) ? $clog2(DEADTIME) : 1;
    localparam int CW1  = CMD_WIDTH + 1;

    typedef enum logic [1:0] {IDLE, RUN, DEAD} state_t;

    logic [CNTW-1:0]             cnt;
    logic [CNTW-1:0]             cnt_nxt;
    logic                        boundary;
    state_t                      st       [CHANNELS];
    logic [DW-1:0]               duty     [CHANNELS];
    logic [DTW-1:0]              dcnt     [CHANNELS];
    logic signed [CMD_WIDTH-1:0] fb       [CHANNELS];
    logic [DW-1:0]               cmd_mag  [CHANNELS];
    logic [CHANNELS-1:0]         dir_done;
    logic [CHANNELS-1:0]         cmd_nz;
    logic [CHANNELS-1:0]         cmd_pos;

    assign boundary = (cnt == CNTW'(PWM_PERIOD - 1));
    assign cnt_nxt  = boundary ? '0 : cnt + CNTW'(1);

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        logic signed [CMD_WIDTH-1:0] cmd;
        logic signed [CMD_WIDTH:0]   cmd_ext;
        logic        [CMD_WIDTH:0]   cmd_abs;

        assign cmd        = jointDutyCmd[g*CMD_WIDTH +: CMD_WIDTH];
        // One extra bit so negating the most negative command cannot overflow.
        assign cmd_ext    = {cmd[CMD_WIDTH-1], cmd};
        assign cmd_abs    = cmd[CMD_WIDTH-1] ? -cmd_ext : cmd_ext;
        assign cmd_nz[g]  = |cmd;
        assign cmd_pos[g] = ~cmd[CMD_WIDTH-1] & (|cmd);
        assign cmd_mag[g] = (cmd_abs > CW1'(PWM_PERIOD)) ? DW'(PWM_PERIOD) : cmd_abs[DW-1:0];
        assign jointFeedback[g*CMD_WIDTH +: CMD_WIDTH] = fb[g];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            DIR      <= '0;
            PWM      <= '0;
            dir_done <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                st[i]   <= IDLE;
                duty[i] <= '0;
                dcnt[i] <= '0;
                fb[i]   <= '0;
            end
        end else begin
            cnt <= cnt_nxt;
            for (int i = 0; i < CHANNELS; i++) begin
                if (!jointEnable[i]) begin
                    st[i]       <= IDLE;
                    PWM[i]      <= 1'b0;
                    duty[i]     <= '0;
                    dcnt[i]     <= '0;
                    dir_done[i] <= 1'b0;
                    fb[i]       <= '0;
                end else if (st[i] == DEAD && !dir_done[i]) begin
                    // Dead-time still running: only the DIR flip can happen here, never a resample.
                    PWM[i] <= 1'b0;
                    if (DEADTIME == 0 || dcnt[i] == DTW'(DEADTIME - 1)) begin
                        DIR[i]      <= ~DIR[i];
                        dir_done[i] <= 1'b1;
                    end else begin
                        dcnt[i] <= dcnt[i] + DTW'(1);
                    end
                end else if (boundary) begin
                    dcnt[i]     <= '0;
                    dir_done[i] <= 1'b0;
                    if (!cmd_nz[i]) begin
                        st[i]   <= IDLE;
                        PWM[i]  <= 1'b0;
                        duty[i] <= '0;
                        fb[i]   <= '0;
                    end else if (cmd_pos[i] == DIR[i]) begin
                        st[i]   <= RUN;
                        PWM[i]  <= 1'b1;
                        duty[i] <= cmd_mag[i];
                        fb[i]   <= cmd_pos[i] ? CMD_WIDTH'(cmd_mag[i]) : -CMD_WIDTH'(cmd_mag[i]);
                    end else begin
                        st[i]   <= DEAD;
                        PWM[i]  <= 1'b0;
                        duty[i] <= '0;
                        fb[i]   <= '0;
                    end
                end else begin
                    PWM[i] <= (st[i] == RUN) && (DW'(cnt_nxt) < duty[i]);
                end
            end
        end
    end
endmodule
